// File: rtl/mem_pkg.sv
// Shared types for the unified memory arbiter: FSM state encoding and grant owner.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int MAX_WAIT = 7;

endpackage

// File: rtl/mem_sram.sv
// Single-port word array with per-byte write enables and a registered read port.
module mem_sram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [DATA_W/8-1:0]      we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read and write share the enable edge, so rdata holds the pre-write word.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/unified_mem_arb.sv
// Instruction/data arbiter in front of one shared word array; one access in flight,
// WAIT extra cycles per access, response pulse in the RESP cycle.
module unified_mem_arb
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned WAIT   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [31:0]         i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [31:0]         d_addr,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output state_t              dbg_state
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [31:0] OFF_MASK = 32'(BYTES - 1);
  localparam logic [2:0]  WAIT_C   = 3'(WAIT);

  state_t             state;
  owner_t             owner, last_owner, new_owner;
  logic [2:0]         cnt;
  logic [IDX_W-1:0]   idx_q, new_idx, acc_idx;
  logic [BYTES-1:0]   we_q, new_we, acc_we, mem_we;
  logic [DATA_W-1:0]  wdata_q, acc_wdata, mem_rdata;
  logic               err_q, new_err, acc_err;
  logic               open_slot, grant_i, grant_d, gnt_any, enter_resp;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{i_addr, d_addr};

  // Handshake: a request is accepted in the cycle its gnt is high; address, we and
  // wdata are sampled on that rising edge and the requester may change them after.
  // rvalid is a one-cycle pulse WAIT+1 cycles after that edge.
  assign open_slot = reset && (state == ST_IDLE || state == ST_RESP);
  assign grant_d   = open_slot && d_req && !(i_req && last_owner == OWN_D);
  assign grant_i   = open_slot && i_req && !grant_d;
  assign gnt_any   = grant_i || grant_d;
  assign i_gnt     = grant_i;
  assign d_gnt     = grant_d;

  assign new_owner = grant_d ? OWN_D : OWN_I;
  assign new_idx   = grant_d ? d_addr[IDX_W+OFF_W-1:OFF_W] : i_addr[IDX_W+OFF_W-1:OFF_W];
  assign new_we    = grant_d ? d_we : '0;
  assign new_err   = grant_d && ((d_addr & OFF_MASK) != '0);

  // With WAIT=0 the array is accessed on the grant edge itself, so use live inputs.
  assign enter_resp = gnt_any ? (WAIT == 0) : (state == ST_WAIT && cnt == WAIT_C);
  assign acc_idx    = gnt_any ? new_idx : idx_q;
  assign acc_we     = gnt_any ? new_we  : we_q;
  assign acc_wdata  = gnt_any ? d_wdata : wdata_q;
  assign acc_err    = gnt_any ? new_err : err_q;
  assign mem_we     = acc_err ? '0 : acc_we;

  mem_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_sram (
    .clk   (clk),
    .en    (enter_resp),
    .we    (mem_we),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= 3'd0;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      idx_q      <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else if (gnt_any) begin
      owner      <= new_owner;
      last_owner <= new_owner;
      idx_q      <= new_idx;
      we_q       <= new_we;
      wdata_q    <= d_wdata;
      err_q      <= new_err;
      if (WAIT == 0) begin
        state <= ST_RESP;
      end else begin
        state <= ST_WAIT;
        cnt   <= 3'd1;
      end
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == WAIT_C) state <= ST_RESP;
          else cnt <= cnt + 3'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;
  assign i_rvalid  = (state == ST_RESP) && (owner == OWN_I);
  assign d_rvalid  = (state == ST_RESP) && (owner == OWN_D);
  assign i_rdata   = i_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && we_q == '0 && !err_q) ? mem_rdata : '0;
  assign d_err     = d_rvalid && err_q;

endmodule
